// File: rtl/modexp_ctrl_if.sv
// Handshake and operand bundle between the modexp sequencer and the Montgomery core.
interface modexp_ctrl_if #(
    parameter int unsigned WIDTH = 512
);
    logic             mont_resetn;
    logic             mont_start;
    logic [WIDTH-1:0] mont_a;
    logic [WIDTH-1:0] mont_b;
    logic [WIDTH-1:0] mont_m;
    logic [WIDTH+1:0] mont_result;
    logic             mont_done;

    // Sequencer side
    modport master (
        output mont_resetn,
        output mont_start,
        output mont_a,
        output mont_b,
        output mont_m,
        input  mont_result,
        input  mont_done
    );

    // Core side
    modport slave (
        input  mont_resetn,
        input  mont_start,
        input  mont_a,
        input  mont_b,
        input  mont_m,
        output mont_result,
        output mont_done
    );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer in the Montgomery domain. Each multiplication
// re-arms the external core, pulses start, waits for done, then decides the next operation.
// A final multiply-by-1 leaves the Montgomery domain.
module modexp_ctrl #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned IDXW  = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_xm,
    input  logic [WIDTH-1:0] in_rm,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_e,
    input  logic [IDXW-1:0]  e_len,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic [15:0]      op_count,
    modexp_ctrl_if.master    mont
);

    localparam int unsigned     SelW     = $clog2(WIDTH);
    localparam logic [IDXW-1:0] WidthIdx = IDXW'(WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StIssueRst,
        StIssueStart,
        StWait,
        StDecide,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        OpSquare,
        OpMult,
        OpPost
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [IDXW-1:0]  len_clamped;
    logic [SelW-1:0]  bit_sel;
    logic [WIDTH-1:0] operand_b;
    logic [1:0]       unused_result_hi;

    assign len_clamped      = (e_len > WidthIdx) ? WidthIdx : e_len;
    // idx never exceeds WIDTH-1 while it is used to select an exponent bit
    assign bit_sel          = idx_q[SelW-1:0];
    assign unused_result_hi = mont.mont_result[WIDTH+1:WIDTH];

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            op_q       <= OpSquare;
            acc_q      <= '0;
            x_q        <= '0;
            m_q        <= '0;
            e_q        <= '0;
            idx_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            m_q        <= m_d;
            e_q        <= e_d;
            idx_q      <= idx_d;
            op_count_q <= op_count_d;
        end
    end

    // Next-state logic: one core multiplication per RST/START/WAIT/DECIDE loop
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        x_d        = x_q;
        m_d        = m_q;
        e_d        = e_q;
        idx_d      = idx_q;
        op_count_d = op_count_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    acc_d      = in_rm;
                    x_d        = in_xm;
                    m_d        = in_m;
                    e_d        = in_e;
                    op_count_d = '0;
                    idx_d      = len_clamped - IDXW'(1);
                    op_d       = (len_clamped == '0) ? OpPost : OpSquare;
                    state_d    = StIssueRst;
                end
            end
            StIssueRst:   state_d = StIssueStart;
            StIssueStart: state_d = StWait;
            StWait: begin
                if (mont.mont_done) begin
                    acc_d      = mont.mont_result[WIDTH-1:0];
                    op_count_d = op_count_q + 16'd1;
                    state_d    = StDecide;
                end
            end
            StDecide: begin
                if (op_q == OpSquare && e_q[bit_sel]) begin
                    op_d    = OpMult;
                    state_d = StIssueRst;
                end else if (op_q == OpPost) begin
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    op_d    = OpPost;
                    state_d = StIssueRst;
                end else begin
                    idx_d   = idx_q - IDXW'(1);
                    op_d    = OpSquare;
                    state_d = StIssueRst;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand B select; op only changes in DECIDE so operands hold through WAIT
    always_comb begin
        operand_b = acc_q;
        unique case (op_q)
            OpSquare: operand_b = acc_q;
            OpMult:   operand_b = x_q;
            OpPost:   operand_b = {{(WIDTH-1){1'b0}}, 1'b1};
            default:  operand_b = acc_q;
        endcase
    end

    assign mont.mont_a      = acc_q;
    assign mont.mont_b      = operand_b;
    assign mont.mont_m      = m_q;
    assign mont.mont_start  = (state_q == StIssueStart);
    // Core held in reset alongside us, and re-armed before every multiplication
    assign mont.mont_resetn = resetn && (state_q != StIssueRst);

    assign result   = acc_q;
    assign op_count = op_count_q;
    assign done     = (state_q == StDone);
    assign busy     = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_modexp_ctrl.sv
// Randomized bench for modexp_ctrl: behavioural Montgomery core plus a reference model
// computing x^e mod m and the expected operand sequence for each run.
module tb_modexp_ctrl;

    localparam int unsigned WIDTH = 512;
    localparam int unsigned IDXW  = 10;

    logic             clk;
    logic             resetn;
    logic             start;
    logic [WIDTH-1:0] in_xm, in_rm, in_m, in_e;
    logic [IDXW-1:0]  e_len;
    logic [WIDTH-1:0] result;
    logic             done, busy;
    logic [15:0]      op_count;

    modexp_ctrl_if #(.WIDTH(WIDTH)) mif ();

    modexp_ctrl #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .in_xm    (in_xm),
        .in_rm    (in_rm),
        .in_m     (in_m),
        .in_e     (in_e),
        .e_len    (e_len),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .op_count (op_count),
        .mont     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_pass   = 0;
    string            cur_test = "init";

    longint unsigned  qa[$];
    longint unsigned  qb[$];
    longint unsigned  model_m  = 0;
    longint unsigned  exp_res  = 0;
    int               exp_ops  = 0;
    int               core_lat = 4;
    bit               inject_req = 0;
    bit               inj_done   = 0;

    logic             core_done = 0;
    logic             core_run  = 0;
    int               core_cnt  = 0;
    longint unsigned  ca = 0, cb = 0, cm = 0;
    logic [WIDTH+1:0] core_res  = '0;

    assign mif.mont_done   = core_done | inj_done;
    assign mif.mont_result = core_res;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s/%s: got %0h, expected %0h", cur_test, tag, got, exp);
    endtask

    function automatic longint unsigned r_mod(input longint unsigned m);
        longint unsigned r = 1;
        repeat (WIDTH) r = (r * 2) % m;
        return r;
    endfunction

    // 2^-1 mod odd m is (m+1)/2, so R^-1 = ((m+1)/2)^WIDTH mod m
    function automatic longint unsigned r_inv(input longint unsigned m);
        longint unsigned h = (m + 1) / 2;
        longint unsigned r = 1;
        repeat (WIDTH) r = (r * h) % m;
        return r;
    endfunction

    function automatic longint unsigned mont(input longint unsigned a, input longint unsigned b,
                                             input longint unsigned m);
        if (m == 0) return 0;
        return (((a % m) * (b % m)) % m) * r_inv(m) % m;
    endfunction

    function automatic logic [WIDTH-1:0] rand_wide();
        logic [WIDTH-1:0] v;
        for (int k = 0; k < WIDTH / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Behavioural core: a*b*R^-1 mod m, core_lat cycles after start, level done until re-armed
    always @(posedge clk) begin
        if (!mif.mont_resetn) begin
            core_done <= 1'b0;
            core_run  <= 1'b0;
        end else if (mif.mont_start) begin
            core_run  <= 1'b1;
            core_done <= 1'b0;
            core_cnt  <= core_lat;
            ca        <= mif.mont_a[63:0];
            cb        <= mif.mont_b[63:0];
            cm        <= mif.mont_m[63:0];
        end else if (core_run) begin
            if (core_cnt <= 1) begin
                core_done <= 1'b1;
                core_run  <= 1'b0;
                core_res  <= {2'b11, {(WIDTH-64){1'b0}}, mont(ca, cb, cm)};
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Handshake monitor: re-arm/start pulse shape, operand order and stability
    initial begin
        int               low_cnt;
        bit               prev_start;
        bit               in_wait;
        logic [WIDTH-1:0] wa, wb;
        longint unsigned  ea, eb;
        low_cnt = 0;
        prev_start = 0;
        in_wait = 0;
        forever begin
            @(negedge clk);
            if (inj_done) inj_done = 0;
            if (!resetn) begin
                low_cnt = 0;
                prev_start = 0;
                in_wait = 0;
            end else begin
                if (mif.mont_start) begin
                    check("start_one_cycle", prev_start, 0);
                    check("one_rst_before_start", low_cnt, 1);
                    check("op_queued", qa.size() != 0, 1);
                    if (qa.size() != 0) begin
                        ea = qa.pop_front();
                        eb = qb.pop_front();
                        check("op_a", mif.mont_a, ea);
                        check("op_b", mif.mont_b, eb);
                        check("op_m", mif.mont_m, model_m);
                    end
                    wa = mif.mont_a;
                    wb = mif.mont_b;
                    in_wait = 1;
                    // Stale done during ISSUE_START must be ignored
                    if (inject_req) inj_done = 1;
                end else if (in_wait && core_done) begin
                    check("wait_stable_a", mif.mont_a, wa);
                    check("wait_stable_b", mif.mont_b, wb);
                    in_wait = 0;
                end
                low_cnt = mif.mont_resetn ? 0 : low_cnt + 1;
                prev_start = mif.mont_start;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_mont_start", mif.mont_start, 0);
        check("rst_mont_resetn", mif.mont_resetn, 0);
        check("rst_op_count", op_count, 0);
        check("rst_result", result, 0);
        check("rst_mont_a", mif.mont_a, 0);
        check("rst_mont_b", mif.mont_b, 0);
        check("rst_mont_m", mif.mont_m, 0);
    endtask

    // Build the reference for one run and pulse start
    task automatic start_run(input longint unsigned x, input longint unsigned m,
                             input logic [WIDTH-1:0] e, input int elen, input int lat);
        int              len;
        int              pop;
        longint unsigned rm, xm, acc, r;
        len = (elen > int'(WIDTH)) ? int'(WIDTH) : elen;
        rm  = r_mod(m);
        xm  = (x * rm) % m;
        qa.delete();
        qb.delete();
        acc = rm;
        r   = 1;
        pop = 0;
        for (int i = len - 1; i >= 0; i--) begin
            qa.push_back(acc);
            qb.push_back(acc);
            acc = mont(acc, acc, m);
            r = (r * r) % m;
            if (e[i]) begin
                pop++;
                qa.push_back(acc);
                qb.push_back(xm);
                acc = mont(acc, xm, m);
                r = (r * x) % m;
            end
        end
        qa.push_back(acc);
        qb.push_back(1);
        exp_res  = r % m;
        exp_ops  = len + pop + 1;
        model_m  = m;
        core_lat = lat;
        @(negedge clk);
        in_xm = {{(WIDTH-64){1'b0}}, xm};
        in_rm = {{(WIDTH-64){1'b0}}, rm};
        in_m  = {{(WIDTH-64){1'b0}}, m};
        in_e  = e;
        e_len = IDXW'(elen);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("core_rst_after_start", mif.mont_resetn, 0);
        check("done_after_start", done, 0);
        // Later input changes must not affect the run
        in_xm = rand_wide();
        in_rm = rand_wide();
        in_m  = rand_wide();
        in_e  = rand_wide();
        e_len = IDXW'($urandom);
    endtask

    task automatic finish_run();
        int budget;
        bit seen;
        budget = exp_ops * (core_lat + 4) + 50;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = done;
        end
        check("done_reached", done, 1);
        check("result", result, exp_res);
        check("op_count", op_count, exp_ops);
        check("ops_consumed", qa.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", done, 1);
        check("busy_in_done", busy, 0);
        check("result_held", result, exp_res);
    endtask

    initial begin
        longint unsigned m, x;
        logic [WIDTH-1:0] e;
        bit got_run;
        resetn = 1'b0;
        start  = 1'b0;
        in_xm  = '0;
        in_rm  = '0;
        in_m   = '0;
        in_e   = '0;
        e_len  = '0;

        cur_test = "reset";
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_core_released", mif.mont_resetn, 1);
        check("idle_busy", busy, 0);

        cur_test = "basic";
        start_run(2, 13, {{(WIDTH-3){1'b0}}, 3'b101}, 3, 20);
        finish_run();
        check("basic_result_6", result, 6);
        check("basic_ops_6", op_count, 6);

        cur_test = "zero_exp";
        start_run(5, 13, rand_wide(), 0, 3);
        finish_run();
        check("zero_result_1", result, 1);
        check("zero_ops_1", op_count, 1);

        cur_test = "sequence";
        start_run(3, 13, {{(WIDTH-4){1'b0}}, 4'b1011}, 4, 3);
        finish_run();
        check("seq_ops_8", op_count, 8);

        cur_test = "random";
        for (int n = 0; n < 6; n++) begin
            m = 64'($urandom_range(1, 32767)) * 2 + 1;
            x = 64'($urandom) % m;
            start_run(x, m, rand_wide(), $urandom_range(0, 40), $urandom_range(1, 5));
            finish_run();
        end
        m = 64'($urandom_range(1, 32767)) * 2 + 1;
        start_run(64'($urandom) % m, m, rand_wide(), $urandom_range(505, 530), 1);
        finish_run();

        cur_test = "clamp";
        m = 64'($urandom_range(1, 32767)) * 2 + 1;
        start_run(64'($urandom) % m, m, {WIDTH{1'b1}}, 600, 2);
        finish_run();
        check("clamp_ops_1025", op_count, 1025);

        cur_test = "back_to_back";
        m = 64'($urandom_range(1, 32767)) * 2 + 1;
        start_run(64'($urandom) % m, m, rand_wide(), 17, 4);
        finish_run();

        cur_test = "busy_start";
        inject_req = 1;
        m = 64'($urandom_range(1, 32767)) * 2 + 1;
        start_run(64'($urandom) % m, m, rand_wide(), 12, 3);
        repeat (25) @(posedge clk);
        @(negedge clk);
        in_xm = rand_wide();
        in_m  = rand_wide();
        in_e  = rand_wide();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run();
        inject_req = 0;

        cur_test = "abort";
        m = 64'($urandom_range(1, 32767)) * 2 + 1;
        start_run(64'($urandom) % m, m, rand_wide(), 10, 8);
        got_run = 0;
        for (int c = 0; c < 200 && !got_run; c++) begin
            @(posedge clk);
            #1;
            got_run = core_run;
        end
        check("abort_reached_wait", got_run, 1);
        @(negedge clk);
        resetn = 1'b0;
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle_core_released", mif.mont_resetn, 1);
        m = 64'($urandom_range(1, 32767)) * 2 + 1;
        start_run(64'($urandom) % m, m, rand_wide(), 9, 2);
        finish_run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencer that computes a 512-bit modular exponentiation by repeatedly issuing Montgomery multiplications to one external `montgomery` core. It uses left-to-right square-and-multiply in the Montgomery domain, followed by a final multiply-by-1 to leave the domain. It owns the core's start and re-arm (reset) handshake and its operand muxing. It sits between the RSA top-level / bus interface and the multiplier core.

## Interface
- `WIDTH`, 512: operand width; the exponent index range is `WIDTH` bits.
- `IDXW`, 10: width of `e_len` and of the internal bit index.
- `clk`  in  1  clock; all logic is rising-edge.
- `resetn`  in  1  reset, synchronous, active-low; clock `clk`.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `in_xm`  in  WIDTH  base in the Montgomery domain: x·R mod m, with R = 2^WIDTH.
- `in_rm`  in  WIDTH  R mod m, the Montgomery one.
- `in_m`  in  WIDTH  modulus; odd, and less than 2^(WIDTH-1).
- `in_e`  in  WIDTH  exponent.
- `e_len`  in  IDXW  number of significant exponent bits; values above `WIDTH` clamp to `WIDTH`.
- `result`  out  WIDTH  x^e mod m; valid while `done` = 1.
- `done`  out  1  high in the DONE state.
- `busy`  out  1  high in every state except IDLE and DONE.
- `op_count`  out  16  number of core multiplications completed in the current run.
- `mont_resetn`  out  1  core reset, active-low.
- `mont_start`  out  1  core start pulse.
- `mont_a`  out  WIDTH  core operand A.
- `mont_b`  out  WIDTH  core operand B.
- `mont_m`  out  WIDTH  core modulus.
- `mont_result`  in  WIDTH+2  core result; only bits [WIDTH-1:0] are used.
- `mont_done`  in  1  core completion level.

## Operation
- Registers:
  - `acc` (WIDTH)
  - `x`, `m`, `e` (WIDTH each), latched at start
  - `idx` (IDXW)
  - `op` ∈ {SQUARE, MULT, POST}
  - `op_count` (16)
- States: IDLE, ISSUE_RST, ISSUE_START, WAIT, DECIDE, DONE.
- **IDLE / DONE**, on `start`:
  - Load `acc`←`in_rm`, `x`←`in_xm`, `m`←`in_m`, `e`←`in_e`, `op_count`←0.
  - Load `idx`←min(`e_len`, `WIDTH`)−1.
  - Set `op`←POST if the clamped `e_len` is 0, else SQUARE.
  - Go to ISSUE_RST.
- **ISSUE_RST**: `mont_resetn`=0 for exactly one cycle; the core is re-armed before every multiplication → ISSUE_START.
- **ISSUE_START**: `mont_start`=1 for exactly one cycle → WAIT.
- **WAIT**: hold until `mont_done`=1; then `acc`←`mont_result[WIDTH-1:0]`, `op_count`++ → DECIDE.
- **DECIDE**, one cycle:
  - `op`=SQUARE and `e[idx]`=1: `op`←MULT → ISSUE_RST.
  - `op`=POST: → DONE.
  - Otherwise, if `idx`=0: `op`←POST → ISSUE_RST.
  - Otherwise: `idx`←`idx`−1, `op`←SQUARE → ISSUE_RST.
- **Operand mux**, a function of `op`:
  - SQUARE: `mont_a`=`acc`, `mont_b`=`acc`.
  - MULT: `mont_a`=`acc`, `mont_b`=`x`.
  - POST: `mont_a`=`acc`, `mont_b`=1.
  - `mont_m`=`m` always.
  - Operands stay constant from ISSUE_RST through WAIT, because the core reads `mont_a` bit-serially.
- `result`=`acc`.
- Multiplications per run = clamped `e_len` + popcount(`e`[len−1:0]) + 1.
- `start` while busy is ignored. Input changes after the start cycle have no effect.

## Timing
- **Reset values** (with `resetn`=0):
  - state = IDLE
  - `done`=0, `busy`=0, `mont_start`=0
  - `mont_resetn`=0
  - `acc`, `op_count`, `result` = 0
  - `mont_a`, `mont_b`, `mont_m` = 0
- Outside reset, `mont_resetn`=1 except in ISSUE_RST.
- Reset mid-run aborts immediately: next cycle is IDLE, and the core is held in reset.
- `start` accepted at edge t: `busy`=1 from t+1, and `mont_resetn`=0 during cycle t+1.
- Per multiplication: 1 (RST) + 1 (START) + L_core (WAIT, up to and including the `mont_done` cycle) + 1 (DECIDE).
- `done` rises on the edge after the final DECIDE and stays high until `start` or reset.
- `mont_done` seen outside WAIT is ignored; a stale DONE from the core is cleared by ISSUE_RST.
- `start` in DONE restarts directly: `done` falls on the next edge.

## Test plan
- **Basic exponentiation.** Bench core model computes a·b·R⁻¹ mod m with latency 20. Inputs: m=13, x=2 (bench supplies `in_xm`, `in_rm`), e=5, `e_len`=3 → `result`=6, `op_count`=6, `done` held high.
- **Zero exponent.** `e_len`=0, m=13 → exactly one POST op, `result`=1, `op_count`=1.
- **Sequence and handshake check.** e=0b1011, `e_len`=4: op order S,M,S,S,M,S,M,P (`op_count`=8). Every `mont_start` pulse is one cycle, is preceded by exactly one `mont_resetn`=0 cycle, and operands are stable during WAIT.
- **Clamping and back-to-back runs.** `e_len`=600 is treated as 512; with e=all-ones, `op_count`=1025. `start` pulsed in DONE starts a second run with new inputs, giving the correct second result.
- **Reset mid-run.** `resetn`=0 during WAIT → IDLE next cycle with all outputs zero. A subsequent `start` yields the correct result.
- **Busy and stale done.** `start` pulsed while busy has no effect on result or `op_count`. A `mont_done` pulse injected during ISSUE_START is ignored.
